// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and constants for the UART RX frame path
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - sampling-stage handshake and received-word bus
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sampled_bit;
    logic                  sample_done;
    logic                  cnt_en;
    logic                  data_samp_en;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        input  sampled_bit, sample_done,
        output cnt_en, data_samp_en, P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        output sampled_bit, sample_done,
        input  cnt_en, data_samp_en, P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - LSB-first shift register, bit index and expected-parity generation
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  clr,
    input  logic                  sampled_bit,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last_bit,
    output logic                  parity_bit
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (shift_en) begin
            // newest bit enters at the MSB so the first bit lands in bit 0
            sr_d  = {sampled_bit, sr_q[DATA_WIDTH-1:1]};
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign data       = sr_q;
    assign last_bit   = (idx_q == IDX_W'(DATA_WIDTH - 1));
    assign parity_bit = (par_typ == PAR_ODD) ? ~^sr_q : ^sr_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART RX frame FSM: start/data/parity/stop sequencing and result strobes
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX_IN,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    uart_rx_frame_ctrl_if.master bus
);
    rx_state_t             state_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  frame_bad_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic                  shift_en;
    logic                  clr;
    logic [DATA_WIDTH-1:0] sr;
    logic                  last_bit;
    logic                  parity_bit;

    assign shift_en = (state_q == ST_DATA) && bus.sample_done;
    assign clr      = (state_q == ST_START) && bus.sample_done && !bus.sampled_bit;

    uart_rx_deser #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deser (
        .clk         (clk),
        .rst         (rst),
        .shift_en    (shift_en),
        .clr         (clr),
        .sampled_bit (bus.sampled_bit),
        .par_typ     (par_typ_q),
        .data        (sr),
        .last_bit    (last_bit),
        .parity_bit  (parity_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            frame_bad_q  <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // frame options are frozen at the falling edge for the whole frame
                    if (!RX_IN) begin
                        state_q   <= ST_START;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                    end
                end
                ST_START: begin
                    if (bus.sample_done) begin
                        state_q <= bus.sampled_bit ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.sample_done && last_bit) begin
                        state_q <= par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (bus.sample_done) begin
                        if (bus.sampled_bit != parity_bit) begin
                            par_err_q   <= 1'b1;
                            frame_bad_q <= 1'b1;
                        end
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bus.sample_done) begin
                        if (!bus.sampled_bit) begin
                            stp_err_q <= 1'b1;
                        end else if (!frame_bad_q) begin
                            p_data_q     <= sr;
                            data_valid_q <= 1'b1;
                        end
                        frame_bad_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // enables drop for at least one IDLE cycle between frames, restarting the edge counter
    assign bus.cnt_en       = (state_q != ST_IDLE);
    assign bus.data_samp_en = (state_q != ST_IDLE);
    assign bus.P_DATA       = p_data_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.par_err      = par_err_q;
    assign bus.stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic RX_IN;
    logic PAR_EN;
    logic PAR_TYP;

    int errors = 0;
    int checks = 0;

    int       dv_cnt = 0;
    int       pe_cnt = 0;
    int       se_cnt = 0;
    logic [7:0] last_word = 8'h00;
    logic [7:0] words [$];

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8)) dut_if ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX_IN   (RX_IN),
        .PAR_EN  (PAR_EN),
        .PAR_TYP (PAR_TYP),
        .bus     (dut_if.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut_if.data_valid) begin
            dv_cnt++;
            last_word = dut_if.P_DATA;
            words.push_back(dut_if.P_DATA);
        end
        if (dut_if.par_err) pe_cnt++;
        if (dut_if.stp_err) se_cnt++;
    end

    task automatic send_bit(input logic b);
        RX_IN = b;
        repeat (2) @(negedge clk);
        dut_if.sampled_bit = b;
        dut_if.sample_done = 1'b1;
        @(negedge clk);
        dut_if.sample_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic sbit);
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        RX_IN   = 1'b0;
        @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(sbit);
        RX_IN = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_counts(input string name, input int dv0, input int pe0, input int se0,
                                input int dv_exp, input int pe_exp, input int se_exp);
        checks++;
        if ((dv_cnt - dv0) !== dv_exp || (pe_cnt - pe0) !== pe_exp || (se_cnt - se0) !== se_exp) begin
            errors++;
            $display("FAIL %s strobes: dv=%0d pe=%0d se=%0d, required dv=%0d pe=%0d se=%0d",
                     name, dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0, dv_exp, pe_exp, se_exp);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_if.P_DATA !== 8'h00) begin
            errors++; $display("FAIL reset_pdata: got %h, required 00", dut_if.P_DATA);
        end
        checks++;
        if ({dut_if.data_valid, dut_if.par_err, dut_if.stp_err} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b, required 000",
                               {dut_if.data_valid, dut_if.par_err, dut_if.stp_err});
        end
        checks++;
        if ({dut_if.cnt_en, dut_if.data_samp_en} !== 2'b00) begin
            errors++; $display("FAIL reset_enables: got %b, required 00",
                               {dut_if.cnt_en, dut_if.data_samp_en});
        end
    endtask

    task automatic test_idle_sample_ignored();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
        @(negedge clk);
        dut_if.sampled_bit = 1'b0;
        dut_if.sample_done = 1'b1;
        @(negedge clk);
        dut_if.sample_done = 1'b0;
        settle();
        check_counts("idle_sample", dv0, pe0, se0, 0, 0, 0);
        checks++;
        if (dut_if.cnt_en !== 1'b0) begin
            errors++; $display("FAIL idle_sample_cnt_en: got %b, required 0", dut_if.cnt_en);
        end
    endtask

    task automatic test_good_no_parity();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        RX_IN   = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({dut_if.cnt_en, dut_if.data_samp_en} !== 2'b11) begin
            errors++; $display("FAIL start_enables: got %b, required 11",
                               {dut_if.cnt_en, dut_if.data_samp_en});
        end
        // raising PAR_EN mid-frame must not add a parity slot
        PAR_EN = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i == 0 || i == 2 || i == 5 || i == 7);
        send_bit(1'b1);
        RX_IN  = 1'b1;
        PAR_EN = 1'b0;
        settle();
        check_counts("a5_noparity", dv0, pe0, se0, 1, 0, 0);
        checks++;
        if (dut_if.P_DATA !== 8'hA5 || last_word !== 8'hA5) begin
            errors++; $display("FAIL a5_pdata: got %h, required a5", dut_if.P_DATA);
        end
    endtask

    task automatic test_parity();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        settle();
        check_counts("even_good", dv0, pe0, se0, 1, 0, 0);
        checks++;
        if (dut_if.P_DATA !== 8'h07) begin
            errors++; $display("FAIL even_good_pdata: got %h, required 07", dut_if.P_DATA);
        end
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        check_counts("even_bad", dv0, pe0, se0, 0, 1, 0);
        checks++;
        if (dut_if.P_DATA !== 8'h07) begin
            errors++; $display("FAIL even_bad_pdata: got %h, required 07", dut_if.P_DATA);
        end
        // frame_bad must be cleared so the next good frame is accepted
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        check_counts("even_after_bad", dv0, pe0, se0, 1, 0, 0);
        checks++;
        if (dut_if.P_DATA !== 8'h81) begin
            errors++; $display("FAIL even_after_bad_pdata: got %h, required 81", dut_if.P_DATA);
        end
    endtask

    task automatic test_stop_error();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check_counts("odd_stop_err", dv0, pe0, se0, 0, 0, 1);
        checks++;
        if (dut_if.P_DATA !== 8'h81) begin
            errors++; $display("FAIL stop_err_pdata: got %h, required 81", dut_if.P_DATA);
        end
    endtask

    task automatic test_start_glitch();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
        PAR_EN = 1'b0;
        RX_IN  = 1'b0;
        @(negedge clk);
        send_bit(1'b1);
        #1;
        checks++;
        if (dut_if.cnt_en !== 1'b0) begin
            errors++; $display("FAIL glitch_cnt_en: got %b, required 0", dut_if.cnt_en);
        end
        settle();
        check_counts("glitch", dv0, pe0, se0, 0, 0, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        check_counts("after_glitch", dv0, pe0, se0, 1, 0, 0);
        checks++;
        if (dut_if.P_DATA !== 8'h3C) begin
            errors++; $display("FAIL after_glitch_pdata: got %h, required 3c", dut_if.P_DATA);
        end
    endtask

    task automatic test_reset_mid_frame();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
        PAR_EN = 1'b0;
        RX_IN  = 1'b0;
        @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        RX_IN = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({dut_if.cnt_en, dut_if.data_samp_en, dut_if.P_DATA} !== 10'h000) begin
            errors++; $display("FAIL async_reset: got en=%b pdata=%h, required en=00 pdata=00",
                               {dut_if.cnt_en, dut_if.data_samp_en}, dut_if.P_DATA);
        end
        @(negedge clk);
        rst = 1'b1;
        settle();
        check_counts("reset_mid", dv0, pe0, se0, 0, 0, 0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        check_counts("after_reset", dv0, pe0, se0, 1, 0, 0);
        checks++;
        if (dut_if.P_DATA !== 8'hFF) begin
            errors++; $display("FAIL after_reset_pdata: got %h, required ff", dut_if.P_DATA);
        end
    endtask

    task automatic test_back_to_back();
        int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
        words.delete();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        check_counts("b2b", dv0, pe0, se0, 2, 0, 0);
        checks++;
        if (words.size() != 2) begin
            errors++; $display("FAIL b2b_words: got %0d words, required 2", words.size());
        end else if (words[0] !== 8'h55 || words[1] !== 8'hAA) begin
            errors++; $display("FAIL b2b_order: got %h %h, required 55 aa", words[0], words[1]);
        end
        checks++;
        if (dut_if.P_DATA !== 8'hAA) begin
            errors++; $display("FAIL b2b_pdata: got %h, required aa", dut_if.P_DATA);
        end
    endtask

    initial begin
        rst                = 1'b0;
        RX_IN              = 1'b1;
        PAR_EN             = 1'b0;
        PAR_TYP            = 1'b0;
        dut_if.sampled_bit = 1'b1;
        dut_if.sample_done = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_idle_sample_ignored();
        test_good_no_parity();
        test_parity();
        test_stop_error();
        test_start_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Downstream consumer of the RX oversampling stage: takes its majority-voted `sampled_bit` / `sample_done` stream and assembles complete UART frames.
- Frame format: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
- Drives the enables for the edge counter and the sampling stage.
- Outputs the parallel word with a one-cycle valid strobe, plus parity and stop error flags.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  system clock (oversampling clock domain).
- rst  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line, already synchronised; idle high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- sampled_bit  input  1  voted bit value from the sampling stage.
- sample_done  input  1  one-cycle strobe; sampled_bit is valid in this cycle.
- cnt_en  output  1  edge/bit counter enable; the counter holds 0 while low.
- data_samp_en  output  1  sampling stage enable.
- P_DATA  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle strobe; P_DATA updated this cycle.
- par_err  output  1  one-cycle strobe, parity mismatch.
- stp_err  output  1  one-cycle strobe, stop bit sampled 0.

Behaviour:
- Reset (async, rst=0): state=IDLE; shift register, bit index, P_DATA all 0; data_valid, par_err, stp_err = 0. Reset mid-frame abandons the frame with no strobes.
- Enables: cnt_en = data_samp_en = (state != IDLE), decoded combinationally from state.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RX_IN==0 at a clk edge -> START.
  - PAR_EN and PAR_TYP are latched on that same edge and held for the whole frame; mid-frame changes are ignored.
- START, on sample_done:
  - sampled_bit==1 -> glitch: back to IDLE, no strobes.
  - sampled_bit==0 -> DATA, bit index cleared to 0.
- DATA, on each sample_done:
  - Shift right: sr <= {sampled_bit, sr[DATA_WIDTH-1:1]} (first bit received ends up in P_DATA[0]).
  - Bit index increments.
  - On the sample_done where index==DATA_WIDTH-1 -> PARITY if latched PAR_EN, else STOP.
- PARITY, on sample_done:
  - Expected bit = ^sr for even, ~^sr for odd.
  - Mismatch -> par_err=1 for exactly one cycle (next cycle) and an internal frame_bad flag is set.
  - -> STOP.
- STOP, on sample_done:
  - sampled_bit==0 -> stp_err=1 for one cycle.
  - sampled_bit==1 and frame_bad clear -> P_DATA <= sr and data_valid=1 for one cycle.
  - Always -> IDLE; frame_bad is cleared.
- Output timing: strobes are registered, asserted in the cycle after the qualifying sample_done edge. P_DATA is stable except on data_valid.
- Errored frames: P_DATA keeps its previous value; the corresponding error strobe is still issued.
- Between sample_done strobes every state holds; no timeout.
- Back-to-back frames: after STOP -> IDLE, the line low in any following cycle starts a new frame immediately. The edge counter restarts from 0 because cnt_en drops for at least one cycle in IDLE.
- sample_done while in IDLE: ignored.

Decomposition:
- Shared uart_rx package holds:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit);
  - DATA_WIDTH default;
  - PAR_TYP encodings (EVEN=0, ODD=1).
- One natural sub-module: uart_rx_deser. It holds the shift register, bit index and parity computation, and exposes shift_en, clr, last_bit and parity_bit.
- FSM and strobe generation stay in uart_rx_frame_ctrl.

Test Plan:
- Good frame, PAR_EN=0, byte 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1 -> data_valid pulses once, P_DATA=0xA5, no error strobes.
- PAR_EN=1, PAR_TYP=0, byte 0x07 with parity bit 1 -> P_DATA=0x07, data_valid.
- Same frame with parity bit 0 -> par_err one cycle, no data_valid, P_DATA unchanged.
- PAR_EN=1, PAR_TYP=1, byte 0x00, parity bit 1, stop bit 0 -> stp_err one cycle, no par_err, no data_valid.
- Start glitch: RX_IN low, then sampled_bit=1 at first sample_done -> back to IDLE, cnt_en drops the next cycle, no strobes. A following good frame 0x3C is received correctly.
- rst pulsed low during DATA bit 4 -> all outputs 0 immediately, state IDLE. Next full frame 0xFF yields data_valid with P_DATA=0xFF.
- Two back-to-back frames 0x55 then 0xAA, no idle gap beyond the stop bit -> two data_valid strobes, P_DATA=0x55 then 0xAA.
